add_round_key_stage: RTL and testbench
======================================

Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage directly downstream of the diffusion block (shift rows + mix columns).
- Holds a local round-key store that the key scheduler loads one 32-bit column word per write.
- XORs each incoming 4x4 state matrix with the stored key for its round, under a valid/ready handshake.
- Its output feeds the next round's substitution stage, or the ciphertext output on the final round.

Parameters:
- NUM_ROUNDS, 11, number of round keys stored (index 0..NUM_ROUNDS-1).
- CNT_W, 16, width of the processed-block counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_clear  in  1  synchronous clear of every key-complete flag.
- key_wr_en  in  1  key word write strobe.
- key_wr_round  in  4  round index of the written word.
- key_wr_col  in  2  column of the word; 3 = first (leftmost) column.
- key_wr_word  in  32  column word; [31:24] to row 3 (top) ... [7:0] to row 0.
- in_valid  in  1  upstream state valid.
- in_ready  out  1  stage accepts the state this cycle.
- in_round  in  4  round index of the incoming state.
- ark_in  in  [7:0] x [3:0][3:0]  state matrix [row][col]; row 3 top, col 3 first.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts.
- ark_out  out  [7:0] x [3:0][3:0]  ark_in XOR round key, same orientation.
- out_round  out  4  round index carried with the result.
- out_final  out  1  out_round == NUM_ROUNDS-1.
- out_err  out  1  in_round was >= NUM_ROUNDS; ark_out = ark_in unmodified.
- blk_count  out  CNT_W  number of accepted states, wraps.

Behaviour:
- Reset (async, rst=1): all outputs 0.
  - Key-complete flags and per-round column-written bits cleared.
  - Key storage contents are don't-care.
  - in_ready is 0 while rst is high.
- Key store:
  - On key_wr_en with key_wr_round < NUM_ROUNDS, write the 4 bytes into column key_wr_col of that round's key and set its column bit.
  - A round is complete when all 4 column bits are set.
  - Writes with key_wr_round >= NUM_ROUNDS are ignored.
  - Rewriting an already-complete round keeps it complete.
  - key_clear zeroes all column bits and complete flags. key_clear and key_wr_en in the same cycle: clear first, then the write sets its column bit.
- Acceptance (combinational):
  - in_ready = !rst && (!out_valid || out_ready) && key_ok(in_round).
  - key_ok is 1 when in_round >= NUM_ROUNDS (error passthrough); otherwise it equals that round's complete flag.
  - A transfer occurs when in_valid && in_ready.
- Latency: 1 cycle, full throughput (one state per cycle when out_ready is held high).
- On transfer, register:
  - ark_out[r][c] = ark_in[r][c] ^ key[in_round][r][c];
  - out_round = in_round;
  - out_final and out_err as defined in Ports;
  - out_valid = 1;
  - blk_count increments by 1, modulo 2^CNT_W.
- Key write hazard: a key write in the same cycle as a transfer using that round does not affect the result; the XOR uses the pre-write key value.
- Output hold:
  - While out_valid && !out_ready, ark_out, out_round, out_final and out_err stay stable and in_ready = 0.
  - out_valid clears when out_ready is high and no new transfer occurs.
- Incomplete key: in_ready stays 0 and in_valid/ark_in are held by upstream. No timeout; the stage resumes on the cycle the key completes.
- Reset mid-operation:
  - out_valid drops immediately and any pending result is lost.
  - Keys must be reloaded before acceptance resumes.
- No bit growth: XOR is bytewise 8-bit. This stage performs no GF arithmetic.

Test Plan:
- Key gating: load round 0 cols 3,2,1 only, hold in_valid with in_round=0 -> in_ready stays 0. Write col 0 -> in_ready=1 that cycle; next cycle out_valid=1.
- XOR check: round 1 key all bytes 8'hA5, ark_in all 8'h0F -> ark_out all 8'hAA, out_round=1, out_final=0, out_err=0. Repeat with key row 3 = {8'h01,8'h02,8'h03,8'h04} loaded via the col words -> top-row bytes placed correctly.
- Throughput/backpressure: 5 back-to-back states with out_ready=1 -> 5 consecutive out_valid cycles, blk_count=5. Drop out_ready for 3 cycles mid-stream -> output held stable, in_ready=0, no data lost or duplicated.
- Final/error flags: in_round=10 with complete key -> out_final=1. in_round=12 -> accepted without a key, out_err=1, ark_out==ark_in.
- Hazard and clear: transfer on round 2 while rewriting round 2 col 3 -> result uses the old key, and the next state uses the new key. key_clear -> in_ready=0 for all rounds < 11.
- Async reset: assert rst mid-stream, between clock edges -> out_valid and blk_count are 0 immediately. After release, no acceptance until keys are reloaded.

Source files
------------

// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage: XORs each accepted 4x4 state with the stored key of its round.
// Keys are loaded one 32-bit column word at a time; a state is accepted only once its round key is complete.
`timescale 1ns/1ps
module add_round_key_stage #(
  parameter int NUM_ROUNDS = 11,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_clear,
  input  logic                   key_wr_en,
  input  logic [3:0]             key_wr_round,
  input  logic [1:0]             key_wr_col,
  input  logic [31:0]            key_wr_word,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_round,
  input  logic [3:0][3:0][7:0]   ark_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0][3:0][7:0]   ark_out,
  output logic [3:0]             out_round,
  output logic                   out_final,
  output logic                   out_err,
  output logic [CNT_W-1:0]       blk_count
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  // Handshake: a transfer happens on a cycle where in_valid && in_ready; the
  // output side completes on out_valid && out_ready, and the output register
  // may be refilled in the same cycle it is drained.

  logic [3:0][3:0][7:0]         key_q [NUM_ROUNDS];
  logic [NUM_ROUNDS-1:0][3:0]   col_bits_q, col_bits_d;
  logic [NUM_ROUNDS-1:0]        key_done;

  logic                         in_err;
  logic                         key_ok;
  logic [3:0][3:0][7:0]         key_sel;
  logic                         transfer;

  logic                         out_valid_q, out_valid_d;
  logic [3:0][3:0][7:0]         ark_q, ark_d;
  logic [3:0]                   round_q;
  logic                         final_q, final_d;
  logic                         err_q;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  // Clear takes effect before the write, so a same-cycle write still marks its column.
  always_comb begin
    col_bits_d = col_bits_q;
    if (key_clear) begin
      col_bits_d = '0;
    end
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (key_wr_en && (key_wr_round == 4'(i))) begin
        col_bits_d[i][key_wr_col] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_bits_q <= '0;
    end else begin
      col_bits_q <= col_bits_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      key_done[i] = &col_bits_q[i];
    end
  end

  // Key contents are not reset; only the column-written bits gate their use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (key_wr_en && (key_wr_round == 4'(i))) begin
        for (int r = 0; r < 4; r++) begin
          key_q[i][r][key_wr_col] <= key_wr_word[8*r +: 8];
        end
      end
    end
  end

  always_comb begin
    in_err  = (in_round > LAST_ROUND);
    key_ok  = in_err;
    key_sel = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (in_round == 4'(i)) begin
        key_sel = key_q[i];
        key_ok  = key_done[i];
      end
    end
  end

  assign in_ready = !rst && (!out_valid_q || out_ready) && key_ok;
  assign transfer = in_valid && in_ready;

  // key_sel reads the registered store, so a same-cycle key write is not seen.
  always_comb begin
    ark_d       = in_err ? ark_in : (ark_in ^ key_sel);
    final_d     = (in_round == LAST_ROUND);
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      cnt_d       = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ark_q       <= '0;
      round_q     <= '0;
      final_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      if (transfer) begin
        ark_q   <= ark_d;
        round_q <= in_round;
        final_q <= final_d;
        err_q   <= in_err;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign ark_out   = ark_q;
  assign out_round = round_q;
  assign out_final = final_q;
  assign out_err   = err_q;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: directed scenarios plus random traffic, all scored
// against a byte-level key-store model and an expected-result queue.
`timescale 1ns/1ps
module tb_add_round_key_stage;

  localparam int NR = 11;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 key_clear;
  logic                 key_wr_en;
  logic [3:0]           key_wr_round;
  logic [1:0]           key_wr_col;
  logic [31:0]          key_wr_word;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_round;
  logic [3:0][3:0][7:0] ark_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0][3:0][7:0] ark_out;
  logic [3:0]           out_round;
  logic                 out_final;
  logic                 out_err;
  logic [CW-1:0]        blk_count;

  add_round_key_stage #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .key_clear(key_clear), .key_wr_en(key_wr_en),
    .key_wr_round(key_wr_round), .key_wr_col(key_wr_col), .key_wr_word(key_wr_word),
    .in_valid(in_valid), .in_ready(in_ready), .in_round(in_round), .ark_in(ark_in),
    .out_valid(out_valid), .out_ready(out_ready), .ark_out(ark_out),
    .out_round(out_round), .out_final(out_final), .out_err(out_err), .blk_count(blk_count)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard and reference model
  int            n_checks = 0;
  int            n_errors = 0;
  logic [133:0]  exp_q[$];
  logic [7:0]    m_key [16][4][4];
  logic [3:0]    m_cols [16];
  logic [CW-1:0] m_count;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit key_ok_m(input int rd);
    if (rd >= NR) return 1'b1;
    return (m_cols[rd] == 4'hF);
  endfunction

  function automatic logic [133:0] expect_entry(input int rd, input logic [3:0][3:0][7:0] st);
    logic [3:0][3:0][7:0] res;
    bit err;
    err = (rd >= NR);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[r][c] = err ? st[r][c] : (st[r][c] ^ m_key[rd][r][c]);
    return {err, (rd == NR - 1), 4'(rd), res};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_count = '0;
    for (int i = 0; i < 16; i++) m_cols[i] = 4'h0;
  endtask

  task automatic check_outputs();
    logic [133:0] e;
    check("out_valid", 160'(out_valid), 160'(exp_q.size() != 0));
    check("blk_count", 160'(blk_count), 160'(m_count));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("ark_out",   160'(ark_out),   160'(e[127:0]));
      check("out_round", 160'(out_round), 160'(e[131:128]));
      check("out_final", 160'(out_final), 160'(e[132]));
      check("out_err",   160'(out_err),   160'(e[133]));
    end
  endtask

  // driver: inputs are set at posedge+1; tick scores one clock cycle
  task automatic tick();
    bit rdy;
    int rd;
    #1;
    rdy = (exp_q.size() == 0 || out_ready) && key_ok_m(int'(in_round));
    check("in_ready", 160'(in_ready), 160'(rdy));
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    if (in_valid && rdy) begin
      exp_q.push_back(expect_entry(int'(in_round), ark_in));
      m_count = m_count + 1'b1;
    end
    if (key_clear) for (int i = 0; i < 16; i++) m_cols[i] = 4'h0;
    rd = int'(key_wr_round);
    if (key_wr_en && rd < NR) begin
      for (int r = 0; r < 4; r++) m_key[rd][r][key_wr_col] = key_wr_word[8*r +: 8];
      m_cols[rd][key_wr_col] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic write_word(input int rd, input int col, input logic [31:0] w);
    key_wr_en    = 1'b1;
    key_wr_round = 4'(rd);
    key_wr_col   = 2'(col);
    key_wr_word  = w;
    tick();
    key_wr_en    = 1'b0;
  endtask

  task automatic load_round_rand(input int rd);
    for (int c = 3; c >= 0; c--) write_word(rd, c, $urandom());
  endtask

  function automatic logic [3:0][3:0][7:0] rand_state();
    logic [3:0][3:0][7:0] s;
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    return s;
  endfunction

  logic [3:0][3:0][7:0] st;
  logic [CW-1:0]        base;

  initial begin
    rst = 1'b1; key_clear = 1'b0; key_wr_en = 1'b0; key_wr_round = '0; key_wr_col = '0;
    key_wr_word = '0; in_valid = 1'b0; in_round = '0; ark_in = '0; out_ready = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) m_key[i][r][c] = 8'h00;

    // reset state
    #2;
    check("rst_out_valid", 160'(out_valid), 160'(0));
    check("rst_blk_count", 160'(blk_count), 160'(0));
    check("rst_ark_out",   160'(ark_out),   160'(0));
    check("rst_in_ready",  160'(in_ready),  160'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs();

    // key gating: three columns are not enough
    in_valid = 1'b1; in_round = 4'd0; ark_in = rand_state();
    write_word(0, 3, $urandom());
    write_word(0, 2, $urandom());
    write_word(0, 1, $urandom());
    check("gate_closed", 160'(in_ready), 160'(0));
    write_word(0, 0, $urandom());
    check("gate_open", 160'(in_ready), 160'(1));
    tick();
    check("gate_out_valid", 160'(out_valid), 160'(1));
    in_valid = 1'b0;

    // XOR with a uniform key
    for (int c = 0; c < 4; c++) write_word(1, c, 32'hA5A5A5A5);
    in_valid = 1'b1; in_round = 4'd1; ark_in = {16{8'h0F}};
    tick();
    in_valid = 1'b0;
    check("xor_aa",    160'(ark_out),   160'({16{8'hAA}}));
    check("xor_round", 160'(out_round), 160'(1));
    check("xor_final", 160'(out_final), 160'(0));
    check("xor_err",   160'(out_err),   160'(0));

    // byte placement: top row 01,02,03,04 from col 3 down to col 0
    write_word(1, 3, 32'h01000000);
    write_word(1, 2, 32'h02000000);
    write_word(1, 1, 32'h03000000);
    write_word(1, 0, 32'h04000000);
    in_valid = 1'b1; ark_in = '0;
    tick();
    in_valid = 1'b0;
    check("row3_bytes", 160'(ark_out[3]), 160'(32'h01020304));
    check("rows_low",   160'(ark_out[2:0]), 160'(0));

    // throughput, then backpressure mid-stream
    base = m_count;
    in_valid = 1'b1; in_round = 4'd1;
    for (int k = 0; k < 5; k++) begin
      ark_in = rand_state();
      tick();
    end
    check("burst_count", 160'(blk_count), 160'(base + 16'd5));
    ark_in = rand_state();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_ready", 160'(in_ready), 160'(0));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();

    // final round and out-of-range round
    load_round_rand(10);
    in_valid = 1'b1; in_round = 4'd10; ark_in = rand_state();
    tick();
    check("final_flag", 160'(out_final), 160'(1));
    st = rand_state();
    in_round = 4'd12; ark_in = st;
    tick();
    in_valid = 1'b0;
    check("err_flag", 160'(out_err), 160'(1));
    check("err_pass", 160'(ark_out), 160'(st));

    // key write racing a transfer on the same round
    load_round_rand(2);
    in_valid = 1'b1; in_round = 4'd2; ark_in = rand_state();
    write_word(2, 3, $urandom());
    ark_in = rand_state();
    tick();
    in_valid = 1'b0;
    tick();

    // clear removes every key
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    for (int r = 0; r < NR; r++) begin
      in_round = 4'(r);
      #0.4;
      check("clr_ready", 160'(in_ready), 160'(0));
    end
    tick();

    // asynchronous reset between edges
    load_round_rand(1);
    in_valid = 1'b1; in_round = 4'd1; ark_in = rand_state();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 160'(out_valid), 160'(0));
    check("arst_blk_count", 160'(blk_count), 160'(0));
    check("arst_in_ready",  160'(in_ready),  160'(0));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs();
    tick();
    check("arst_no_key", 160'(in_ready), 160'(0));
    in_valid = 1'b0;
    load_round_rand(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();

    // random traffic
    for (int rd = 0; rd < NR; rd++) load_round_rand(rd);
    for (int k = 0; k < 400; k++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_round     = 4'($urandom_range(0, 13));
      ark_in       = rand_state();
      out_ready    = ($urandom_range(0, 3) != 0);
      key_wr_en    = ($urandom_range(0, 9) < 3);
      key_wr_round = 4'($urandom_range(0, 12));
      key_wr_col   = 2'($urandom_range(0, 3));
      key_wr_word  = $urandom();
      key_clear    = ($urandom_range(0, 99) < 2);
      tick();
    end
    in_valid = 1'b0; key_wr_en = 1'b0; key_clear = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
